// File: rtl/async_out_pacer_pkg.sv
// Shared constants and FSM state encodings for the async output pacer.
// DEFAULT_HOLD is also used to size the receive-side input filter.
package async_out_pacer_pkg;

    localparam int DEFAULT_HOLD  = 32;
    localparam int DEFAULT_DEPTH = 4;

    // Encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } pacer_state_e;

endpackage

// File: rtl/async_out_fifo.sv
// DEPTH x 1 first-word-fall-through FIFO used as the symbol queue of async_out_pacer.
module async_out_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             pushOk;
    logic             popOk;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rdPtr_q];

    // A push while full is dropped even if a pop happens in the same cycle.
    assign pushOk = push_i & ~full_o;
    assign popOk  = pop_i & ~empty_o;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (popOk) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({pushOk, popOk})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the count guards every read.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/async_out_pacer.sv
// Paces a 1-bit symbol stream onto a slow async pin, HOLD clocks per symbol plus a trailing gap.
// Define ASYNC_OUT_SB_IO_EN to drive the pin through a registered SB_IO (adds one clock of latency).
module async_out_pacer
    import async_out_pacer_pkg::*;
#(
    parameter int   HOLD       = DEFAULT_HOLD,
    parameter int   DEPTH      = DEFAULT_DEPTH,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_data,
    output logic in_ready,
    output logic busy,
    output logic pin
);

    localparam int            CW         = $clog2(HOLD);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD - 1);

    pacer_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pinReg_q, pinReg_d;
    logic          fifoPush;
    logic          fifoPop;
    logic          fifoHead;
    logic          fifoFull;
    logic          fifoEmpty;

    // in_ready depends only on registered FIFO state, never on this cycle's pop.
    assign in_ready = ~fifoFull & ~rst;
    assign fifoPush = in_valid & in_ready;
    assign busy     = ~fifoEmpty | (state_q != ST_IDLE);

    async_out_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifoPush),
        .data_i  (in_data),
        .pop_i   (fifoPop),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Counter is reloaded on reaching zero so every symbol and gap lasts exactly HOLD clocks.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pinReg_d = pinReg_q;
        fifoPop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pinReg_d = IDLE_LEVEL;
                if (!fifoEmpty) begin
                    fifoPop  = 1'b1;
                    pinReg_d = fifoHead;
                    cnt_d    = CNT_RELOAD;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_RELOAD;
                    if (!fifoEmpty) begin
                        fifoPop  = 1'b1;
                        pinReg_d = fifoHead;
                    end else begin
                        pinReg_d = IDLE_LEVEL;
                        state_d  = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                pinReg_d = IDLE_LEVEL;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                pinReg_d = IDLE_LEVEL;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pinReg_q <= IDLE_LEVEL;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pinReg_q <= pinReg_d;
        end
    end

`ifdef ASYNC_OUT_SB_IO_EN
    SB_IO #(
        .PIN_TYPE (6'b0101_01),
        .PULLUP   (1'b0)
    ) u_pin_io (
        .PACKAGE_PIN   (pin),
        .CLOCK_ENABLE  (1'b1),
        .OUTPUT_CLK    (clk),
        .OUTPUT_ENABLE (1'b1),
        .D_OUT_0       (pinReg_q)
    );
`else
    assign pin = pinReg_q;
`endif

endmodule

// File: tb/tb_async_out_pacer.sv
// Directed self-checking bench for async_out_pacer (HOLD=32, DEPTH=4, IDLE_LEVEL=1, default build).
module tb_async_out_pacer;

    localparam int HOLD  = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 200;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic in_valid = 1'b0;
    logic in_data  = 1'b0;
    logic in_ready;
    logic busy;
    logic pin;

    int errors     = 0;
    int checks     = 0;
    int cyc        = 0;
    int minSpacing = 1000000;
    int lastEdge   = 0;
    int edgeCount  = 0;
    bit haveEdge   = 1'b0;
    logic lastPin  = 1'b1;

    async_out_pacer #(
        .HOLD       (HOLD),
        .DEPTH      (DEPTH),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .pin      (pin)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tracks the closest pair of pin edges outside reset; truncation by reset is allowed.
    always @(negedge clk) begin
        if (rst) begin
            haveEdge = 1'b0;
            lastPin  = pin;
        end else if (pin !== lastPin) begin
            if (haveEdge && (cyc - lastEdge) < minSpacing) minSpacing = cyc - lastEdge;
            haveEdge = 1'b1;
            lastEdge = cyc;
            lastPin  = pin;
            edgeCount++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    // Offers one symbol for a single clock, starting and ending on a falling edge.
    task automatic applyStimulus(input logic d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitPin(input logic level, output int n);
        n = 0;
        while (pin !== level && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic runLength(input logic level, output int n);
        n = 0;
        while (pin === level && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic gapLength(output int n);
        n = 0;
        while (busy === 1'b1 && pin === 1'b1 && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pin !== 1'b1) begin errors++; $display("[TB] FAIL reset_pin: got %b expected 1", pin); end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", in_ready); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready: got %b expected 1", in_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL release_busy: got %b expected 0", busy); end
        checks++;
        if (pin !== 1'b1) begin errors++; $display("[TB] FAIL release_pin: got %b expected 1", pin); end
    endtask

    task automatic test_single_symbol(input string tag);
        int t0;
        int n;
        applyStimulus(1'b0);
        t0 = cyc;
        checks++;
        if (pin !== 1'b1) begin errors++; $display("[TB] FAIL %s_early_pin: got %b expected 1", tag, pin); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s_busy: got %b expected 1", tag, busy); end
        waitPin(1'b0, n);
        checks++;
        if (cyc - t0 !== 1) begin errors++; $display("[TB] FAIL %s_latency: got %0d expected 1", tag, cyc - t0); end
        runLength(1'b0, n);
        checks++;
        if (n !== HOLD) begin errors++; $display("[TB] FAIL %s_width: got %0d expected %0d", tag, n, HOLD); end
        gapLength(n);
        checks++;
        if (n !== HOLD) begin errors++; $display("[TB] FAIL %s_gap: got %0d expected %0d", tag, n, HOLD); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy_end: got %b expected 0", tag, busy); end
        checks++;
        if (cyc - t0 !== 65) begin errors++; $display("[TB] FAIL %s_busy_fall: got %0d expected 65", tag, cyc - t0); end
    endtask

    task automatic test_back_to_back;
        int t0;
        int n;
        in_valid = 1'b1;
        in_data  = 1'b0;
        @(negedge clk);
        t0 = cyc;
        in_data = 1'b1;
        @(negedge clk);
        in_data = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        runLength(1'b0, n);
        checks++;
        if (n !== HOLD - 1) begin errors++; $display("[TB] FAIL b2b_first_rest: got %0d expected %0d", n, HOLD - 1); end
        checks++;
        if (cyc - t0 !== 33) begin errors++; $display("[TB] FAIL b2b_first_end: got %0d expected 33", cyc - t0); end
        runLength(1'b1, n);
        checks++;
        if (n !== HOLD) begin errors++; $display("[TB] FAIL b2b_second: got %0d expected %0d", n, HOLD); end
        runLength(1'b0, n);
        checks++;
        if (n !== HOLD) begin errors++; $display("[TB] FAIL b2b_third: got %0d expected %0d", n, HOLD); end
        gapLength(n);
        checks++;
        if (n !== HOLD) begin errors++; $display("[TB] FAIL b2b_gap: got %0d expected %0d", n, HOLD); end
        checks++;
        if (cyc - t0 !== 129) begin errors++; $display("[TB] FAIL b2b_busy_fall: got %0d expected 129", cyc - t0); end
    endtask

    task automatic test_fifo_full;
        logic [4:0] offerBits = 5'b00101;
        logic [4:0] expReady  = 5'b01111;
        int n;
        applyStimulus(1'b0);
        waitPin(1'b0, n);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = offerBits[i];
            checks++;
            if (in_ready !== expReady[i]) begin
                errors++;
                $display("[TB] FAIL full_ready_%0d: got %b expected %b", i, in_ready, expReady[i]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        runLength(1'b0, n);
        checks++;
        if (n !== HOLD - 5) begin errors++; $display("[TB] FAIL full_first_rest: got %0d expected %0d", n, HOLD - 5); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_back: got %b expected 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            runLength(offerBits[i], n);
            checks++;
            if (n !== HOLD) begin errors++; $display("[TB] FAIL full_order_%0d: got %0d expected %0d", i, n, HOLD); end
        end
        gapLength(n);
        checks++;
        if (n !== HOLD) begin errors++; $display("[TB] FAIL full_gap: got %0d expected %0d", n, HOLD); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_gap_push;
        int gapStart;
        int n;
        applyStimulus(1'b0);
        waitPin(1'b0, n);
        runLength(1'b0, n);
        gapStart = cyc;
        repeat (4) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL gap_ready: got %b expected 1", in_ready); end
        applyStimulus(1'b0);
        waitPin(1'b0, n);
        checks++;
        if (cyc - gapStart !== 33) begin errors++; $display("[TB] FAIL gap_held: got %0d expected 33", cyc - gapStart); end
        runLength(1'b0, n);
        checks++;
        if (n !== HOLD) begin errors++; $display("[TB] FAIL gap_symbol: got %0d expected %0d", n, HOLD); end
        gapLength(n);
        checks++;
        if (n !== HOLD) begin errors++; $display("[TB] FAIL gap_trailing: got %0d expected %0d", n, HOLD); end
    endtask

    task automatic test_reset_mid;
        int bad;
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        repeat (8) @(negedge clk);
        checks++;
        if (pin !== 1'b0) begin errors++; $display("[TB] FAIL mid_before: got %b expected 0", pin); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pin !== 1'b1) begin errors++; $display("[TB] FAIL mid_pin: got %b expected 1", pin); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (pin !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("[TB] FAIL mid_queue_lost: got %0d active samples expected 0", bad); end
        test_single_symbol("after_reset");
    endtask

    task automatic test_edge_spacing;
        checks++;
        if (edgeCount < 10) begin errors++; $display("[TB] FAIL edge_count: got %0d expected >=10", edgeCount); end
        checks++;
        if (minSpacing < HOLD) begin errors++; $display("[TB] FAIL edge_spacing: got %0d expected >=%0d", minSpacing, HOLD); end
    endtask

    initial begin
        test_reset();
        test_single_symbol("single");
        test_back_to_back();
        test_fifo_full();
        test_gap_push();
        test_reset_mid();
        test_edge_spacing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
